// File: rtl/mul_div_unit_pkg.sv
// Shared opcodes, HI/LO move encodings and default latencies for the mul/div unit.
// MULDIV_MACC_EN enables the multiply-accumulate opcodes.
package mul_div_unit_pkg;

  typedef enum logic [3:0] {
    MUL_MULT  = 4'd0,
    MUL_MULTU = 4'd1,
    MUL_DIV   = 4'd2,
    MUL_DIVU  = 4'd3,
    MUL_MADD  = 4'd4,
    MUL_MADDU = 4'd5,
    MUL_MSUB  = 4'd6,
    MUL_MSUBU = 4'd7,
    MUL_NONE  = 4'd8
  } mul_op_e;

  localparam logic [1:0] MTHILO_LO   = 2'b00;
  localparam logic [1:0] MTHILO_HI   = 2'b01;
  localparam logic [1:0] MTHILO_NONE = 2'b10;

  localparam logic [1:0] MFHILO_NONE = 2'b00;
  localparam logic [1:0] MFHILO_LO   = 2'b01;
  localparam logic [1:0] MFHILO_HI   = 2'b10;

  localparam int DEF_MUL_LAT = 5;
  localparam int DEF_DIV_LAT = 10;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_e;

  function automatic logic op_valid(logic [3:0] op);
`ifdef MULDIV_MACC_EN
    return op <= 4'd7;
`else
    return op <= 4'd3;
`endif
  endfunction

  function automatic logic op_is_div(logic [3:0] op);
    return (op == MUL_DIV) || (op == MUL_DIVU);
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Decoder-to-mul/div handshake: opcode, HI/LO moves, operands, start/busy.
// master = execute-stage issue side, slave = the unit.
interface mul_div_unit_if;
  logic [3:0]  mul_op;
  logic [1:0]  mthilo;
  logic [1:0]  mfhilo;
  logic [31:0] a;
  logic [31:0] b;
  logic        start;
  logic        busy;
  logic [31:0] hilo_out;

  modport master (
    output mul_op, mthilo, mfhilo, a, b,
    input  start, busy, hilo_out
  );

  modport slave (
    input  mul_op, mthilo, mfhilo, a, b,
    output start, busy, hilo_out
  );
endinterface

// File: rtl/mul_div_alu.sv
// Combinational 64-bit HI/LO result: mul, div/rem, optional accumulate.
// MULDIV_MACC_EN adds the 64-bit add/sub path for MADD/MSUB.
module mul_div_alu
  import mul_div_unit_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] res
);

  logic        sgn;
  logic [63:0] ax;
  logic [63:0] bx;
  logic [63:0] prod;
  logic [31:0] am;
  logic [31:0] bm;
  logic [31:0] bd;
  logic [31:0] q;
  logic [31:0] r;
  logic [31:0] qs;
  logic [31:0] rs;

  always_comb begin
    sgn  = (op == MUL_MULT) || (op == MUL_DIV) ||
           (op == MUL_MADD) || (op == MUL_MSUB);
    ax   = sgn ? {{32{a[31]}}, a} : {32'd0, a};
    bx   = sgn ? {{32{b[31]}}, b} : {32'd0, b};
    prod = ax * bx;
    // Divide magnitudes, then restore signs; avoids -2^31/-1 overflow.
    am   = (sgn && a[31]) ? -a : a;
    bm   = (sgn && b[31]) ? -b : b;
    bd   = (bm == 32'd0) ? 32'd1 : bm;
    q    = am / bd;
    r    = am % bd;
    qs   = (sgn && (a[31] ^ b[31])) ? -q : q;
    rs   = (sgn && a[31]) ? -r : r;
    res  = prod;
    case (op)
      MUL_DIV,
      MUL_DIVU:
        res = (b == 32'd0) ? {hi, lo} : {rs, qs};
`ifdef MULDIV_MACC_EN
      MUL_MADD,
      MUL_MADDU:
        res = {hi, lo} + prod;
      MUL_MSUB,
      MUL_MSUBU:
        res = {hi, lo} - prod;
`endif
      default:
        res = prod;
    endcase
  end

endmodule

// File: rtl/mul_div_unit.sv
// Execute-stage multi-cycle mul/div unit with private HI/LO registers.
// MULDIV_MACC_EN enables MADD/MADDU/MSUB/MSUBU.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int DIV_LAT = DEF_DIV_LAT
) (
  input logic            clk,
  input logic            rst_n,
  mul_div_unit_if.slave  io
);

  state_e      state;
  logic [3:0]  cnt;
  logic        busy_q;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;
  logic [63:0] alu_res;

  assign io.start = op_valid(io.mul_op);
  assign io.busy  = busy_q;

  always_comb begin
    case (io.mfhilo)
      MFHILO_LO:   io.hilo_out = lo;
      MFHILO_HI:   io.hilo_out = hi;
      MFHILO_NONE: io.hilo_out = 32'd0;
      default:     io.hilo_out = 32'd0;
    endcase
  end

  mul_div_alu u_alu (
    .op  (io.mul_op),
    .a   (io.a),
    .b   (io.b),
    .hi  (hi),
    .lo  (lo),
    .res (alu_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= 4'd0;
      busy_q  <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (io.start) begin
            {pend_hi, pend_lo} <= alu_res;
            cnt    <= op_is_div(io.mul_op) ? 4'(DIV_LAT)
                                           : 4'(MUL_LAT);
            busy_q <= 1'b1;
            state  <= ST_RUN;
          end else begin
            case (io.mthilo)
              MTHILO_LO:   lo <= io.a;
              MTHILO_HI:   hi <= io.a;
              MTHILO_NONE: ;
              default:     ;
            endcase
          end
        end
        ST_RUN: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            hi     <= pend_hi;
            lo     <= pend_lo;
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases plus random traffic
// against a cycle-timestamped arithmetic model of HI/LO.
module tb_mul_div_unit;

  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;
`ifdef MULDIV_MACC_EN
  localparam bit MACC = 1'b1;
`else
  localparam bit MACC = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mul_div_unit_if bus();

  mul_div_unit #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 50)
        $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit is_op(logic [3:0] op);
    return (op <= 4'd3) || (MACC && op <= 4'd7);
  endfunction

  function automatic logic [63:0] ref_result(logic [3:0] op,
      logic [31:0] a, logic [31:0] b, logic [31:0] hi, logic [31:0] lo);
    longint      sa  = longint'($signed(a));
    longint      sb  = longint'($signed(b));
    logic [63:0] ua  = {32'd0, a};
    logic [63:0] ub  = {32'd0, b};
    logic [63:0] acc = {hi, lo};
    logic [63:0] sp  = 64'(sa * sb);
    logic [63:0] up  = ua * ub;
    longint      q;
    longint      r;
    logic [63:0] uq;
    logic [63:0] ur;
    case (op)
      4'd0: return sp;
      4'd1: return up;
      4'd2: begin
        if (b == 32'd0) return acc;
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      4'd3: begin
        if (b == 32'd0) return acc;
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      4'd4: return acc + sp;
      4'd5: return acc + up;
      4'd6: return acc - sp;
      4'd7: return acc - up;
      default: return acc;
    endcase
  endfunction

  logic [31:0] m_hi   = 32'd0;
  logic [31:0] m_lo   = 32'd0;
  logic [63:0] m_pend = 64'd0;
  bit          m_run  = 1'b0;
  longint      tcyc   = 0;
  longint      m_done = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hi   = 32'd0;
      m_lo   = 32'd0;
      m_pend = 64'd0;
      m_run  = 1'b0;
      tcyc   = 0;
      m_done = 0;
    end else begin
      tcyc++;
      if (m_run) begin
        if (tcyc == m_done) begin
          {m_hi, m_lo} = m_pend;
          m_run = 1'b0;
        end
      end else if (is_op(bus.mul_op)) begin
        m_pend = ref_result(bus.mul_op, bus.a, bus.b, m_hi, m_lo);
        m_done = tcyc + ((bus.mul_op == 4'd2 || bus.mul_op == 4'd3)
                         ? DIV_LAT : MUL_LAT);
        m_run  = 1'b1;
      end else if (bus.mthilo == 2'b00) begin
        m_lo = bus.a;
      end else if (bus.mthilo == 2'b01) begin
        m_hi = bus.a;
      end
    end
  end

  function automatic logic [31:0] m_read(logic [1:0] sel);
    return (sel == 2'b01) ? m_lo : (sel == 2'b10) ? m_hi : 32'd0;
  endfunction

  // Every-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    chk("start",    32'(bus.start), 32'(is_op(bus.mul_op)));
    chk("busy",     32'(bus.busy),  32'(m_run));
    chk("hilo_out", bus.hilo_out,   m_read(bus.mfhilo));
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(logic [3:0] op, logic [31:0] av, logic [31:0] bv);
    bus.mul_op = op;
    bus.a      = av;
    bus.b      = bv;
    tick();
    bus.mul_op = 4'd8;
  endtask

  task automatic wait_idle(string name, int lat);
    int n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk(name, 32'(n), 32'(lat));
  endtask

  task automatic read(string name, logic [1:0] sel, logic [31:0] exp);
    bus.mfhilo = sel;
    #1;
    chk(name, bus.hilo_out, exp);
    bus.mfhilo = 2'b00;
  endtask

  task automatic move(logic [1:0] sel, logic [31:0] v);
    bus.mthilo = sel;
    bus.a      = v;
    tick();
    bus.mthilo = 2'b10;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.mul_op = 4'd8;
    bus.mthilo = 2'b10;
    bus.mfhilo = 2'b00;
    bus.a      = 32'd0;
    bus.b      = 32'd0;
    repeat (2) @(posedge clk);
    #2;
    read("rst_hi", 2'b10, 32'd0);
    read("rst_lo", 2'b01, 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    tick();

    issue(4'd0, 32'hFFFF_FFFE, 32'd3);
    wait_idle("mult_lat", MUL_LAT);
    read("mult_hi", 2'b10, 32'hFFFF_FFFF);
    read("mult_lo", 2'b01, 32'hFFFF_FFFA);

    issue(4'd2, 32'hFFFF_FFF9, 32'd2);
    wait_idle("div_lat", DIV_LAT);
    read("div_lo", 2'b01, 32'hFFFF_FFFD);
    read("div_hi", 2'b10, 32'hFFFF_FFFF);

    issue(4'd3, 32'd1234, 32'd0);
    wait_idle("divu0_lat", DIV_LAT);
    read("divu0_lo", 2'b01, 32'hFFFF_FFFD);
    read("divu0_hi", 2'b10, 32'hFFFF_FFFF);

    move(2'b01, 32'h1234_5678);
    read("mthi", 2'b10, 32'h1234_5678);

    move(2'b00, 32'hAAAA_5555);
    read("mtlo", 2'b01, 32'hAAAA_5555);
    issue(4'd1, 32'd16, 32'd16);
    bus.mthilo = 2'b00;
    bus.a      = 32'hDEAD_BEEF;
    tick();
    bus.mthilo = 2'b10;
    wait_idle("mtlo_busy_lat", MUL_LAT - 1);
    read("mtlo_busy_lo", 2'b01, 32'h0000_0100);
    read("mtlo_busy_hi", 2'b10, 32'd0);

    issue(4'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle("ovf_lat", DIV_LAT);
    read("ovf_lo", 2'b01, 32'h8000_0000);
    read("ovf_hi", 2'b10, 32'd0);

    bus.mthilo = 2'b00;
    issue(4'd1, 32'd2, 32'd3);
    bus.mthilo = 2'b10;
    wait_idle("opmove_lat", MUL_LAT);
    read("opmove_lo", 2'b01, 32'd6);

    bus.mul_op = 4'd12;
    #1;
    chk("undef_start", 32'(bus.start), 32'd0);
    tick();
    bus.mul_op = 4'd8;
    chk("undef_busy", 32'(bus.busy), 32'd0);

    move(2'b01, 32'd0);
    move(2'b00, 32'hFFFF_FFFF);
    bus.mul_op = 4'd5;
    bus.a      = 32'd1;
    bus.b      = 32'd1;
    #1;
    chk("maddu_start", 32'(bus.start), 32'(MACC));
    tick();
    bus.mul_op = 4'd8;
    wait_idle("maddu_lat", MACC ? MUL_LAT : 0);
    read("maddu_hi", 2'b10, MACC ? 32'd1 : 32'd0);
    read("maddu_lo", 2'b01, MACC ? 32'd0 : 32'hFFFF_FFFF);

    issue(4'd2, 32'd100, 32'd7);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(bus.busy), 32'd0);
    read("rst_mid_hi", 2'b10, 32'd0);
    read("rst_mid_lo", 2'b01, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    issue(4'd1, 32'd6, 32'd7);
    wait_idle("post_rst_lat", MUL_LAT);
    read("post_rst_lo", 2'b01, 32'd42);
    read("post_rst_hi", 2'b10, 32'd0);

    issue(4'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle("b2b_mul_lat", MUL_LAT);
    read("b2b_mul_hi", 2'b10, 32'hFFFF_FFFE);
    read("b2b_mul_lo", 2'b01, 32'd1);
    issue(4'd3, 32'd100, 32'd7);
    chk("b2b_accept", 32'(bus.busy), 32'd1);
    wait_idle("b2b_div_lat", DIV_LAT);
    read("b2b_div_lo", 2'b01, 32'd14);
    read("b2b_div_hi", 2'b10, 32'd2);

    repeat (3000) begin
      bus.mul_op = ($urandom_range(0, 3) == 0)
                   ? 4'($urandom_range(0, 15)) : 4'd8;
      bus.mthilo = 2'($urandom);
      bus.mfhilo = 2'($urandom);
      bus.a      = pick();
      bus.b      = pick();
      tick();
    end

    bus.mul_op = 4'd8;
    bus.mthilo = 2'b10;
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
